// File: rtl/pdp8_pkg.sv
// Shared types for the PDP-8 execution-unit transaction scoreboard.
//   err_code_e  : error codes reported on err_code alongside an err pulse
//   sb_state_e  : scoreboard compare state
//   txn_entry_t : one expected memory transaction (fields sized for the widest
//                 supported bus; narrower buses zero-extend into them)
//   outcome_t   : one compare result waiting to be reported
package pdp8_pkg;

  // Widest address/data bus the entry struct can carry.
  localparam int unsigned MaxAddrWidth = 32;
  localparam int unsigned MaxDataWidth = 32;

  typedef enum logic [2:0] {
    ErrNone       = 3'd0,
    ErrKind       = 3'd1,
    ErrAddr       = 3'd2,
    ErrWrData     = 3'd3,
    ErrRdData     = 3'd4,
    ErrUnexpected = 3'd5,
    ErrOverflow   = 3'd6,
    ErrTimeout    = 3'd7
  } err_code_e;

  typedef enum logic [0:0] {
    StCheck  = 1'b0,
    StRdWait = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic                    is_wr;
    logic                    chk_data;
    logic [MaxAddrWidth-1:0] addr;
    logic [MaxDataWidth-1:0] data;
  } txn_entry_t;

  typedef struct packed {
    logic      valid;
    logic      is_err;
    err_code_e code;
  } outcome_t;

  localparam outcome_t OutcomeNone = '{valid: 1'b0, is_err: 1'b0, code: ErrNone};

  function automatic outcome_t mk_match();
    outcome_t o;
    o = '{valid: 1'b1, is_err: 1'b0, code: ErrNone};
    return o;
  endfunction

  function automatic outcome_t mk_err(input err_code_e c);
    outcome_t o;
    o = '{valid: 1'b1, is_err: 1'b1, code: c};
    return o;
  endfunction

endpackage

// File: rtl/txn_fifo.sv
// Simple in-order FIFO holding expected transactions.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   push_i, wdata_i  : write one entry (ignored when full)
//   pop_i, rdata_o   : drop the head entry (ignored when empty); rdata_o shows the head
//   full_o, empty_o  : occupancy flags
// Push and pop in the same cycle both take effect.
module txn_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  // Pointers carry one extra bit so full and empty differ only in the MSB.
  logic [AW:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/exec_txn_scoreboard.sv
// Memory-transaction scoreboard for the PDP-8 execution unit.
// A reference model pushes expected transactions; each DUT memory request pops
// and compares the head entry. Results are reported as registered pulses
// (match / err + err_code), a sticky error flag and saturating counters.
//   clk, reset                : clock, asynchronous active-high reset
//   exp_*                     : expected-transaction push interface, exp_ready = not full
//   exec_rd_* / exec_wr_*     : observed DUT memory request bus
//   match, err, err_code      : one-cycle result pulses
//   err_sticky                : any error since reset
//   pass_count, fail_count    : saturating outcome counters
//   idle                      : queue empty and no read-data check in flight
// ADDR_WIDTH/DATA_WIDTH must not exceed the package Max*Width.
module exec_txn_scoreboard
  import pdp8_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exp_valid,
  input  logic                  exp_is_wr,
  input  logic [ADDR_WIDTH-1:0] exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_chk_data,
  output logic                  exp_ready,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic [DATA_WIDTH-1:0] exec_rd_data,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  match,
  output logic                  err,
  output logic [2:0]            err_code,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  idle
);

  localparam int unsigned EntryW = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned TmoW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned NCand  = 5;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [2:0]           inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(inc);
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Expected-transaction queue
  // ---------------------------------------------------------------------------
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [EntryW-1:0] push_vec, head_vec;
  txn_entry_t        head;

  assign push_vec = {exp_is_wr, exp_chk_data, exp_addr, exp_data};

  txn_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (exp_valid),
    .wdata_i (push_vec),
    .pop_i   (fifo_pop),
    .rdata_o (head_vec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    head          = '0;
    head.is_wr    = head_vec[EntryW-1];
    head.chk_data = head_vec[EntryW-2];
    head.addr     = MaxAddrWidth'(head_vec[DATA_WIDTH +: ADDR_WIDTH]);
    head.data     = MaxDataWidth'(head_vec[DATA_WIDTH-1:0]);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  sb_state_e               state_q, state_d;
  logic [MaxDataWidth-1:0] rd_exp_q, rd_exp_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  outcome_t                pend_q, pend_d;
  logic                    match_q, match_d;
  logic                    err_q, err_d;
  err_code_e               code_q, code_d;
  logic                    sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]    pass_q, pass_d;
  logic [CNT_WIDTH-1:0]    fail_q, fail_d;

  // ---------------------------------------------------------------------------
  // Request compare
  // ---------------------------------------------------------------------------
  logic                  req_any;
  logic                  enter_rd_wait;
  logic [ADDR_WIDTH-1:0] req_addr;
  outcome_t              req_out;

  assign req_any  = exec_rd_req | exec_wr_req;
  assign fifo_pop = req_any & ~fifo_empty;
  assign req_addr = exec_wr_req ? exec_wr_addr : exec_rd_addr;

  always_comb begin
    req_out       = OutcomeNone;
    enter_rd_wait = 1'b0;
    if (req_any) begin
      if (fifo_empty) begin
        req_out = mk_err(ErrUnexpected);
      end else if (exec_rd_req && exec_wr_req) begin
        req_out = mk_err(ErrKind);
      end else if (head.is_wr != exec_wr_req) begin
        req_out = mk_err(ErrKind);
      end else if (head.addr != MaxAddrWidth'(req_addr)) begin
        req_out = mk_err(ErrAddr);
      end else if (head.is_wr && (head.data != MaxDataWidth'(exec_wr_data))) begin
        req_out = mk_err(ErrWrData);
      end else if (!head.is_wr && head.chk_data) begin
        // Outcome decided next cycle when the read data returns.
        enter_rd_wait = 1'b1;
      end else begin
        req_out = mk_match();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data check, overflow and timeout outcomes
  // ---------------------------------------------------------------------------
  outcome_t rdw_out, ovf_out, tmo_out;

  always_comb begin
    rdw_out = OutcomeNone;
    if (state_q == StRdWait) begin
      rdw_out = (MaxDataWidth'(exec_rd_data) == rd_exp_q) ? mk_match() : mk_err(ErrRdData);
    end
  end

  assign ovf_out = (exp_valid && fifo_full) ? mk_err(ErrOverflow) : OutcomeNone;

  always_comb begin
    tmo_out = OutcomeNone;
    tmo_d   = tmo_q;
    if ((TIMEOUT == 0) || fifo_empty || req_any) begin
      tmo_d = '0;
    end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
      tmo_out = mk_err(ErrTimeout);
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outcome arbitration: the deferred outcome goes first (it is oldest), then
  // overflow, timeout, and the two compare results with errors ahead of matches.
  // The first valid outcome is reported, the second is parked in pend_q. Counters
  // and the sticky flag update when an outcome is produced, not when reported.
  // ---------------------------------------------------------------------------
  outcome_t cand [NCand];
  outcome_t first, second;
  logic [2:0] n_pass, n_fail;

  always_comb begin
    cand[0] = pend_q;
    cand[1] = ovf_out;
    cand[2] = tmo_out;
    if (req_out.is_err && !rdw_out.is_err) begin
      cand[3] = req_out;
      cand[4] = rdw_out;
    end else begin
      cand[3] = rdw_out;
      cand[4] = req_out;
    end

    first  = OutcomeNone;
    second = OutcomeNone;
    for (int i = 0; i < NCand; i++) begin
      if (cand[i].valid) begin
        if (!first.valid) begin
          first = cand[i];
        end else if (!second.valid) begin
          second = cand[i];
        end
      end
    end

    n_pass = '0;
    n_fail = '0;
    for (int i = 1; i < NCand; i++) begin
      if (cand[i].valid && cand[i].is_err)  n_fail = n_fail + 3'd1;
      if (cand[i].valid && !cand[i].is_err) n_pass = n_pass + 3'd1;
    end
  end

  always_comb begin
    state_d  = enter_rd_wait ? StRdWait : StCheck;
    rd_exp_d = enter_rd_wait ? head.data : rd_exp_q;
    match_d  = first.valid & ~first.is_err;
    err_d    = first.valid & first.is_err;
    code_d   = err_d ? first.code : ErrNone;
    pend_d   = second;
    sticky_d = sticky_q | (n_fail != 3'd0);
    pass_d   = sat_add(pass_q, n_pass);
    fail_d   = sat_add(fail_q, n_fail);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StCheck;
      rd_exp_q <= '0;
      tmo_q    <= '0;
      pend_q   <= OutcomeNone;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ErrNone;
      sticky_q <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_exp_q <= rd_exp_d;
      tmo_q    <= tmo_d;
      pend_q   <= pend_d;
      match_q  <= match_d;
      err_q    <= err_d;
      code_q   <= code_d;
      sticky_q <= sticky_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  assign exp_ready  = ~fifo_full;
  assign match      = match_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign err_sticky = sticky_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign idle       = fifo_empty && (state_q == StCheck);

endmodule

// File: tb/tb_exec_txn_scoreboard.sv
module tb_exec_txn_scoreboard;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 12;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          exp_valid, exp_is_wr, exp_chk_data, exp_ready;
  logic [AW-1:0] exp_addr, exec_rd_addr, exec_wr_addr;
  logic [DW-1:0] exp_data, exec_rd_data, exec_wr_data;
  logic          exec_rd_req, exec_wr_req;
  logic          match, err, err_sticky, idle;
  logic [2:0]    err_code;
  logic [CW-1:0] pass_count, fail_count;

  always #5 clk = ~clk;

  exec_txn_scoreboard #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (8),
    .TIMEOUT    (16),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .exp_valid    (exp_valid),
    .exp_is_wr    (exp_is_wr),
    .exp_addr     (exp_addr),
    .exp_data     (exp_data),
    .exp_chk_data (exp_chk_data),
    .exp_ready    (exp_ready),
    .exec_rd_req  (exec_rd_req),
    .exec_rd_addr (exec_rd_addr),
    .exec_rd_data (exec_rd_data),
    .exec_wr_req  (exec_wr_req),
    .exec_wr_addr (exec_wr_addr),
    .exec_wr_data (exec_wr_data),
    .match        (match),
    .err          (err),
    .err_code     (err_code),
    .err_sticky   (err_sticky),
    .pass_count   (pass_count),
    .fail_count   (fail_count),
    .idle         (idle)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_pass = 0;
  int unsigned exp_fail = 0;
  // Expected result pulses, oldest first: {match, err, err_code}
  logic [4:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_match();
    sb_q.push_back(5'b10000);
    exp_pass++;
  endtask

  task automatic expect_err(input logic [2:0] c);
    sb_q.push_back({2'b01, c});
    exp_fail++;
  endtask

  // Every result pulse must correspond to the oldest expected outcome.
  always @(negedge clk) begin : monitor
    logic [4:0] e;
    if (match || err) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        assert (0) else begin
          n_bad++;
          $error("FAIL unexpected_pulse: observed %b expected no pulse", {match, err, err_code});
        end
      end else begin
        e = sb_q.pop_front();
        assert ({match, err, err_code} === e) else begin
          n_bad++;
          $error("FAIL pulse: observed %b expected %b", {match, err, err_code}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic chk);
    exp_valid    = 1'b1;
    exp_is_wr    = wr;
    exp_addr     = a;
    exp_data     = d;
    exp_chk_data = chk;
    step();
    exp_valid    = 1'b0;
  endtask

  task automatic req_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exec_wr_req  = 1'b1;
    exec_wr_addr = a;
    exec_wr_data = d;
    step();
    exec_wr_req  = 1'b0;
  endtask

  // Read request, then memory returns rdata in the following cycle.
  task automatic req_rd(input logic [AW-1:0] a, input logic [DW-1:0] rdata);
    exec_rd_req  = 1'b1;
    exec_rd_addr = a;
    step();
    exec_rd_req  = 1'b0;
    exec_rd_data = rdata;
    step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      step();
    end
    check(tag, sb_q.size(), 0);
  endtask

  logic early;

  initial begin
    reset = 1'b1;
    exp_valid = 0; exp_is_wr = 0; exp_addr = '0; exp_data = '0; exp_chk_data = 0;
    exec_rd_req = 0; exec_rd_addr = '0; exec_rd_data = '0;
    exec_wr_req = 0; exec_wr_addr = '0; exec_wr_data = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset values
    check("rst_ready", exp_ready, 1);
    check("rst_pulses", {match, err, err_code}, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_idle", idle, 1);
    check("rst_counts", {pass_count, fail_count}, 0);

    // Matching write, result one cycle after the request
    push_exp(1'b1, 12'o0200, 12'o1234, 1'b0);
    expect_match();
    req_wr(12'o0200, 12'o1234);
    check("wr_match_lat", match, 1);
    drain("drain_wr");
    check("wr_pass", pass_count, exp_pass);

    // Data-checked read with wrong return data
    push_exp(1'b0, 12'o0050, 12'o7777, 1'b1);
    expect_err(3'd4);
    req_rd(12'o0050, 12'o7776);
    check("rd_err", {err, err_code}, {1'b1, 3'd4});
    drain("drain_rd");
    check("rd_sticky", err_sticky, 1);
    check("rd_fail", fail_count, exp_fail);

    // Request with empty queue
    expect_err(3'd5);
    req_wr(12'o0123, 12'o0);
    check("unexp_code", {err, err_code}, {1'b1, 3'd5});
    check("unexp_idle", idle, 1);
    drain("drain_unexp");

    // Assorted compare patterns
    push_exp(1'b0, 12'o0010, 12'o0, 1'b0);
    expect_match();
    req_rd(12'o0010, 12'o5555);
    push_exp(1'b1, 12'o0020, 12'o1111, 1'b0);
    expect_err(3'd2);
    req_wr(12'o0021, 12'o1111);
    push_exp(1'b1, 12'o0030, 12'o2222, 1'b0);
    expect_err(3'd3);
    req_wr(12'o0030, 12'o2223);
    push_exp(1'b0, 12'o0040, 12'o0, 1'b0);
    expect_err(3'd1);
    req_wr(12'o0040, 12'o0);
    push_exp(1'b1, 12'o0060, 12'o0, 1'b0);
    expect_err(3'd1);
    exec_rd_req = 1'b1; exec_rd_addr = 12'o0060;
    exec_wr_req = 1'b1; exec_wr_addr = 12'o0060; exec_wr_data = 12'o0;
    step();
    exec_rd_req = 1'b0; exec_wr_req = 1'b0;
    push_exp(1'b0, 12'o0070, 12'o4321, 1'b1);
    expect_match();
    req_rd(12'o0070, 12'o4321);
    drain("drain_mix");
    check("mix_idle", idle, 1);
    check("mix_counts", {pass_count, fail_count}, {exp_pass[CW-1:0], exp_fail[CW-1:0]});

    // Overflow: ninth push is dropped
    for (int i = 0; i < 8; i++) push_exp(1'b1, 12'o0400 + AW'(i), DW'(i), 1'b0);
    check("full_ready", exp_ready, 0);
    expect_err(3'd6);
    push_exp(1'b1, 12'o0777, 12'o0777, 1'b0);
    check("ovf_code", {err, err_code}, {1'b1, 3'd6});
    for (int i = 0; i < 8; i++) begin
      expect_match();
      req_wr(12'o0400 + AW'(i), DW'(i));
    end
    drain("drain_ovf");
    check("ovf_idle", idle, 1);
    check("ovf_ready", exp_ready, 1);

    // Timeout after 16 waiting cycles, entry retained
    push_exp(1'b1, 12'o0300, 12'o3030, 1'b0);
    expect_err(3'd7);
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      early = early | err;
    end
    check("tmo_early", early, 0);
    step();
    check("tmo_code", {err, err_code}, {1'b1, 3'd7});
    check("tmo_retained", idle, 0);
    expect_match();
    req_wr(12'o0300, 12'o3030);
    drain("drain_tmo");
    check("tmo_counts", {pass_count, fail_count}, {exp_pass[CW-1:0], exp_fail[CW-1:0]});

    // Request during RD_WAIT: error reported first, read match deferred
    push_exp(1'b0, 12'o0500, 12'o5555, 1'b1);
    push_exp(1'b1, 12'o0501, 12'o0001, 1'b0);
    expect_err(3'd2);
    expect_match();
    exec_rd_req = 1'b1; exec_rd_addr = 12'o0500;
    step();
    exec_rd_req  = 1'b0;
    exec_rd_data = 12'o5555;
    exec_wr_req  = 1'b1; exec_wr_addr = 12'o0777; exec_wr_data = 12'o0001;
    step();
    exec_wr_req  = 1'b0;
    check("both_err", {err, err_code}, {1'b1, 3'd2});
    step();
    check("both_defer", {match, err}, 2'b10);
    drain("drain_both");
    check("both_counts", {pass_count, fail_count}, {exp_pass[CW-1:0], exp_fail[CW-1:0]});

    // Reset in the middle of RD_WAIT with entries still queued
    push_exp(1'b0, 12'o0600, 12'o0006, 1'b1);
    push_exp(1'b1, 12'o0601, 12'o0001, 1'b0);
    push_exp(1'b1, 12'o0602, 12'o0002, 1'b0);
    exec_rd_req = 1'b1; exec_rd_addr = 12'o0600;
    step();
    exec_rd_req  = 1'b0;
    exec_rd_data = 12'o0007;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", exp_ready, 1);
    check("mid_rst_pulses", {match, err, err_code}, 0);
    check("mid_rst_sticky", err_sticky, 0);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_counts", {pass_count, fail_count}, 0);
    exp_pass = 0;
    exp_fail = 0;
    step();
    step();
    reset = 1'b0;
    repeat (5) step();
    check("post_rst_idle", idle, 1);
    check("post_rst_counts", {pass_count, fail_count}, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
